// File: rtl/tdr_pkg.sv
// Shared types, width helpers and default timing for the TDR delay-sweep controller.
package tdr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT_SAMPLE,
        ST_GUARD,
        ST_EMIT,
        ST_DONE
    } sweep_state_t;

    localparam int unsigned DEF_NUM_TAPS       = 64;
    localparam int unsigned DEF_NUM_AVG        = 16;
    localparam int unsigned DEF_GUARD_CYCLES   = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    function automatic int unsigned tap_width(input int unsigned num_taps);
        return $clog2(num_taps);
    endfunction

    // Count must hold 0..num_avg inclusive.
    function automatic int unsigned count_width(input int unsigned num_avg);
        return $clog2(num_avg + 1);
    endfunction

    // Interval timer loads (cycles - 1) for whichever interval is longer.
    function automatic int unsigned timer_width(input int unsigned guard_cycles,
                                                input int unsigned timeout_cycles);
        int unsigned longest;
        longest = (guard_cycles > timeout_cycles) ? guard_cycles : timeout_cycles;
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/tdr_interval_timer.sv
// Loadable down-counter; expire_c flags the last cycle of a loaded interval while running.
module tdr_interval_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    output logic             expire_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire_c = run && (count == '0);

endmodule

// File: rtl/tdr_sweep_ctrl.sv
// Sweeps a TDR core across all sampling taps, averaging NUM_AVG acquisitions per tap.
// Optional threshold fault detection is enabled with macro TDR_SWEEP_THRESH_EN.
module tdr_sweep_ctrl
    import tdr_pkg::*;
#(
    parameter int unsigned NUM_TAPS       = DEF_NUM_TAPS,
    parameter int unsigned NUM_AVG        = DEF_NUM_AVG,
    parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout_err,
    output logic                              core_enable,
    output logic                              core_trigger,
    output logic [tap_width(NUM_TAPS)-1:0]    core_tap_sel,
    input  logic                              core_sample_valid,
    input  logic                              core_sampled_value,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [tap_width(NUM_TAPS)-1:0]    res_tap,
    output logic [count_width(NUM_AVG)-1:0]   res_count
`ifdef TDR_SWEEP_THRESH_EN
    ,
    input  logic [count_width(NUM_AVG)-1:0]   thresh,
    output logic                              fault_found,
    output logic [tap_width(NUM_TAPS)-1:0]    fault_tap
`endif
);

    localparam int unsigned TAP_W = tap_width(NUM_TAPS);
    localparam int unsigned CNT_W = count_width(NUM_AVG);
    localparam int unsigned TMR_W = timer_width(GUARD_CYCLES, TIMEOUT_CYCLES);

    localparam logic [TAP_W-1:0] LAST_TAP     = TAP_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_REP     = CNT_W'(NUM_AVG - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GUARD_LOAD   = TMR_W'(GUARD_CYCLES - 1);

    sweep_state_t     state;
    logic [CNT_W-1:0] rep;
    logic [CNT_W-1:0] acc;

    logic             sample_evt_c;
    logic             timeout_evt_c;
    logic             acq_done_c;
    logic             handshake_c;
    logic [CNT_W-1:0] acc_next_c;
    logic             tmr_load_c;
    logic [TMR_W-1:0] tmr_load_val_c;
    logic             tmr_run_c;
    logic             tmr_expire_c;

    // Acquisition events; a valid sample in the timeout cycle wins over the timeout.
    always_comb begin
        sample_evt_c   = (state == ST_WAIT_SAMPLE) && core_sample_valid;
        timeout_evt_c  = (state == ST_WAIT_SAMPLE) && !core_sample_valid && tmr_expire_c;
        acq_done_c     = sample_evt_c || timeout_evt_c;
        handshake_c    = (state == ST_EMIT) && res_valid && res_ready;
        acc_next_c     = acc + CNT_W'(sample_evt_c && core_sampled_value);
        tmr_load_c     = (state == ST_FIRE) || acq_done_c || handshake_c;
        tmr_load_val_c = (state == ST_FIRE) ? TIMEOUT_LOAD : GUARD_LOAD;
        tmr_run_c      = (state == ST_WAIT_SAMPLE) || (state == ST_GUARD);
    end

    tdr_interval_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_load_val_c),
        .run      (tmr_run_c),
        .expire_c (tmr_expire_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            core_tap_sel <= '0;
            rep          <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            core_enable  <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            core_trigger <= 1'b0;
            res_valid    <= 1'b0;
            res_tap      <= '0;
            res_count    <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            core_enable  <= 1'b0;
            core_trigger <= 1'b0;
            res_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            core_trigger <= 1'b0;
            done         <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_FIRE;
                        core_tap_sel <= '0;
                        rep          <= '0;
                        acc          <= '0;
                        timeout_err  <= 1'b0;
                        busy         <= 1'b1;
                        core_enable  <= 1'b1;
                        core_trigger <= 1'b1;
                    end
                end
                ST_FIRE: begin
                    state <= ST_WAIT_SAMPLE;
                end
                ST_WAIT_SAMPLE: begin
                    if (acq_done_c) begin
                        rep <= rep + CNT_W'(1);
                        acc <= acc_next_c;
                        if (timeout_evt_c) begin
                            timeout_err <= 1'b1;
                        end
                        if (rep == LAST_REP) begin
                            state     <= ST_EMIT;
                            res_valid <= 1'b1;
                            res_tap   <= core_tap_sel;
                            res_count <= acc_next_c;
                        end else begin
                            state <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    if (tmr_expire_c) begin
                        state        <= ST_FIRE;
                        core_trigger <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    // Tap select only moves here, so the next guard lets the core settle.
                    if (handshake_c) begin
                        res_valid <= 1'b0;
                        if (core_tap_sel == LAST_TAP) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            core_tap_sel <= core_tap_sel + TAP_W'(1);
                            rep          <= '0;
                            acc          <= '0;
                            state        <= ST_GUARD;
                        end
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    core_enable <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TDR_SWEEP_THRESH_EN
    // First accepted result at or above thresh is latched for the rest of the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_found <= 1'b0;
            fault_tap   <= '0;
        end else if ((state == ST_IDLE) && start) begin
            fault_found <= 1'b0;
            fault_tap   <= '0;
        end else if (handshake_c && !abort && !fault_found && (res_count >= thresh)) begin
            fault_found <= 1'b1;
            fault_tap   <= core_tap_sel;
        end
    end
`else
    // Threshold tracking is compiled out; the sweep path is unchanged.
`endif

endmodule

// File: tb/tb_tdr_sweep_ctrl.sv
// Directed-plus-random bench for tdr_sweep_ctrl with a behavioural core and host model.
module tb_tdr_sweep_ctrl;

    localparam int NT = 4;
    localparam int NA = 3;
    localparam int GC = 3;
    localparam int TC = 20;
    localparam int TW = $clog2(NT);
    localparam int CW = $clog2(NA + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic          core_enable;
    logic          core_trigger;
    logic [TW-1:0] core_tap_sel;
    logic          core_sample_valid;
    logic          core_sampled_value;
    logic          res_valid;
    logic          res_ready;
    logic [TW-1:0] res_tap;
    logic [CW-1:0] res_count;
`ifdef TDR_SWEEP_THRESH_EN
    logic [CW-1:0] thresh;
    logic          fault_found;
    logic [TW-1:0] fault_tap;
`endif

    tdr_sweep_ctrl #(
        .NUM_TAPS       (NT),
        .NUM_AVG        (NA),
        .GUARD_CYCLES   (GC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err),
        .core_enable        (core_enable),
        .core_trigger       (core_trigger),
        .core_tap_sel       (core_tap_sel),
        .core_sample_valid  (core_sample_valid),
        .core_sampled_value (core_sampled_value),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_tap            (res_tap),
        .res_count          (res_count)
`ifdef TDR_SWEEP_THRESH_EN
        ,
        .thresh             (thresh),
        .fault_found        (fault_found),
        .fault_tap          (fault_tap)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    bit vals [NT][NA];
    bit drop [NT][NA];
    int trig_k = 0;
    int exp_tap_next = 0;
    int done_num = 0;
    bit pend_done = 0;
    bit ready_rand = 0;
    int stall_tap = 0;
    int stall_left = 0;
    int last_trig_cyc = 0;
    int last_wait = 0;

    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [TW-1:0] prev_tap = '0;
    logic [CW-1:0] prev_cnt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected count: ones delivered by the core model; timed-out acquisitions count as 0.
    function automatic int exp_count(input int t);
        int s = 0;
        for (int r = 0; r < NA; r++) s += (drop[t][r] ? 0 : int'(vals[t][r]));
        return s;
    endfunction

    task automatic set_vals(input int mode);
        for (int t = 0; t < NT; t++) begin
            for (int r = 0; r < NA; r++) begin
                drop[t][r] = 1'b0;
                case (mode)
                    0:       vals[t][r] = (t == 2);
                    1:       vals[t][r] = 1'($urandom_range(0, 1));
                    2:       vals[t][r] = 1'b1;
                    default: vals[t][r] = (t == 2) || (t == 1 && r == 0) || (t == 3 && r < 2);
                endcase
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: answers each trigger after a random latency unless the acquisition is dropped.
    initial begin
        core_sample_valid  = 1'b0;
        core_sampled_value = 1'b0;
        forever begin
            @(negedge clk);
            if (core_trigger && !rst) begin
                int tp;
                int rp;
                int lat;
                tp = trig_k / NA;
                rp = trig_k % NA;
                check("trig_tap", 32'(core_tap_sel), 32'(tp));
                if (rp != 0) check("trig_gap", 32'(cyc - last_trig_cyc), 32'(1 + last_wait + GC));
                last_trig_cyc = cyc;
                trig_k++;
                if (tp < NT && drop[tp][rp]) begin
                    last_wait = TC;
                    repeat (TC) @(negedge clk);
                    check("tmo_pending", 32'(timeout_err), 0);
                    @(negedge clk);
                    check("tmo_set", 32'(timeout_err), 1);
                end else begin
                    lat = int'($urandom_range(1, 4));
                    last_wait = lat;
                    repeat (lat) @(posedge clk);
                    #1;
                    core_sample_valid  = 1'b1;
                    core_sampled_value = (tp < NT) ? vals[tp][rp] : 1'b0;
                    @(posedge clk);
                    #1;
                    core_sample_valid  = 1'b0;
                    core_sampled_value = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Host model: always-ready, random-ready, or a fixed stall on one tap.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && res_valid && int'(res_tap) == stall_tap) begin
                res_ready = 1'b0;
                stall_left--;
            end else begin
                res_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Result scoreboard and hold-stability monitor.
    always @(negedge clk) begin
        if (pend_done) begin
            check("done_after_last", 32'(done), 1);
            pend_done = 1'b0;
        end
        if (!rst && res_valid && res_ready) begin
            check("res_tap", 32'(res_tap), 32'(exp_tap_next));
            check("res_count", 32'(res_count), 32'(exp_count(exp_tap_next)));
            if (exp_tap_next == NT - 1) pend_done = 1'b1;
            exp_tap_next++;
        end
        if (!rst && res_valid && prev_valid && !prev_ready) begin
            check("hold_tap", 32'(res_tap), 32'(prev_tap));
            check("hold_cnt", 32'(res_count), 32'(prev_cnt));
            check("hold_no_trig", 32'(core_trigger), 0);
        end
        if (done) done_num++;
        prev_valid = res_valid;
        prev_ready = res_ready;
        prev_tap   = res_tap;
        prev_cnt   = res_count;
    end

    task automatic check_idle();
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_err", 32'(timeout_err), 0);
        check("idle_enable", 32'(core_enable), 0);
        check("idle_trigger", 32'(core_trigger), 0);
        check("idle_tap_sel", 32'(core_tap_sel), 0);
        check("idle_res_valid", 32'(res_valid), 0);
        check("idle_res_tap", 32'(res_tap), 0);
        check("idle_res_count", 32'(res_count), 0);
`ifdef TDR_SWEEP_THRESH_EN
        check("idle_fault", 32'(fault_found), 0);
        check("idle_fault_tap", 32'(fault_tap), 0);
`endif
    endtask

    task automatic start_sweep();
        @(posedge clk);
        #1;
        trig_k = 0;
        exp_tap_next = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_trigger", 32'(core_trigger), 1);
        check("start_busy", 32'(busy), 1);
        check("start_enable", 32'(core_enable), 1);
        check("start_err_clr", 32'(timeout_err), 0);
        check("start_tap0", 32'(core_tap_sel), 0);
    endtask

    task automatic wait_done(input int budget, input bit poke);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) got = 1'b1;
            else if (poke && busy && $urandom_range(0, 15) == 0) start = 1'b1;
        end
        start = 1'b0;
        check("sweep_done", 32'(got), 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_pulse_end", 32'(done), 0);
        check("done_busy_low", 32'(busy), 0);
        check("done_enable_low", 32'(core_enable), 0);
        check("all_results", 32'(exp_tap_next), 32'(NT));
    endtask

    task automatic wait_handshake(input int tap);
        bit got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (res_valid && res_ready && int'(res_tap) == tap) got = 1'b1;
        end
        check("reach_handshake", 32'(got), 1);
    endtask

    initial begin
        int snap;
        bit got;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
`ifdef TDR_SWEEP_THRESH_EN
        thresh = CW'(NA);
`endif
        set_vals(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle();

        // Only tap 2 reflects; results 0,0,3,0 and 12 triggers.
        set_vals(0);
        start_sweep();
        wait_done(3000, 1'b0);
        after_done();
        check("trig_total", 32'(trig_k), 32'(NT * NA));

        // Random data, random ready, 10-cycle stall on tap 1, start pokes while busy.
        set_vals(1);
        ready_rand = 1'b1;
        stall_tap = 1;
        stall_left = 10;
        start_sweep();
        wait_done(3000, 1'b1);
        after_done();
        check("stall_used", 32'(stall_left), 0);
        ready_rand = 1'b0;

        // Second acquisition of tap 0 never answered.
        set_vals(2);
        drop[0][1] = 1'b1;
        start_sweep();
        wait_done(3000, 1'b0);
        after_done();
        check("err_sticky", 32'(timeout_err), 1);

        // Abort in the guard period of tap 2, then a full restart.
        set_vals(1);
        start_sweep();
        wait_handshake(1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_guard_tap", 32'(core_tap_sel), 2);
        check("abort_busy_before", 32'(busy), 1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_res_valid", 32'(res_valid), 0);
        check("abort_enable", 32'(core_enable), 0);
        snap = done_num;
        repeat (10) @(negedge clk);
        check("abort_no_done", 32'(done_num), 32'(snap));
        check("abort_no_more_res", 32'(exp_tap_next), 2);
        set_vals(1);
        start_sweep();
        wait_done(3000, 1'b0);
        after_done();

        // Abort while a result is held unaccepted.
        set_vals(1);
        stall_tap = 0;
        stall_left = 1000;
        start_sweep();
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        check("emit_reached", 32'(got), 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_emit_valid", 32'(res_valid), 0);
        check("abort_emit_busy", 32'(busy), 0);
        check("abort_emit_no_res", 32'(exp_tap_next), 0);
        stall_left = 0;
        repeat (10) @(negedge clk);

        // Mid-sweep reset, then a clean sweep.
        set_vals(1);
        ready_rand = 1'b1;
        start_sweep();
        repeat ($urandom_range(20, 45)) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle();
        repeat (10) @(negedge clk);
        set_vals(1);
        start_sweep();
        wait_done(3000, 1'b1);
        after_done();
        ready_rand = 1'b0;

`ifdef TDR_SWEEP_THRESH_EN
        // Counts 0,1,3,2 against thresh 2: first hit is tap 2 and stays latched.
        thresh = CW'(2);
        set_vals(3);
        start_sweep();
        check("fault_cleared", 32'(fault_found), 0);
        wait_handshake(2);
        @(negedge clk);
        check("fault_found", 32'(fault_found), 1);
        check("fault_tap", 32'(fault_tap), 2);
        wait_done(3000, 1'b0);
        after_done();
        check("fault_found_kept", 32'(fault_found), 1);
        check("fault_tap_kept", 32'(fault_tap), 2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
